// File: rtl/key_expansion_ctrl_pkg.sv
// Shared types and constants for the AES-128 key expansion controller.
// The xtime helper is used both for rcon stepping and for GF(2^8) arithmetic.
package key_expansion_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] shifted;
        shifted = {a[6:0], 1'b0};
        return a[7] ? (shifted ^ RCON_POLY) : shifted;
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_round_keys.sv
// Combinational AES-128 key-schedule step: next round key from previous key and rcon word.
// The S-box is computed arithmetically (GF inverse followed by the affine map).
module round_keys
    import key_expansion_ctrl_pkg::*;
(
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic [31:0]  rcon,
    output logic [127:0] key_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse is x^254; zero maps to zero naturally
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] b;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    assign w0_s = key_in[127:96];
    assign w1_s = key_in[95:64];
    assign w2_s = key_in[63:32];
    assign w3_s = key_in[31:0];

    // Chained word XORs of one AES-128 expansion round
    always_comb begin
        n0_s = w0_s ^ sub_word({w3_s[23:0], w3_s[31:24]}) ^ rcon;
        n1_s = w1_s ^ n0_s;
        n2_s = w2_s ^ n1_s;
        n3_s = w3_s ^ n2_s;
        if (rst) begin
            key_out = 128'h0;
        end else begin
            key_out = {n0_s, n1_s, n2_s, n3_s};
        end
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key expansion controller: fills an 11-entry round-key store one round per cycle
// and serves registered reads from it.
module key_expansion_ctrl
    import key_expansion_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    localparam int         NUM_KEYS = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         keys_valid_q, keys_valid_d;
    logic [127:0] rd_key_q, rd_key_d;
    logic [127:0] store_q [NUM_KEYS];
    logic [127:0] store_d [NUM_KEYS];

    logic         accept_s;
    logic         expand_s;
    logic [3:0]   prev_idx_s;
    logic [127:0] prev_key_s;
    logic [127:0] step_key_s;

    assign prev_idx_s = rnd_q - 4'd1;
    assign prev_key_s = (prev_idx_s < 4'(NUM_KEYS)) ? store_q[prev_idx_s] : 128'h0;

    round_keys u_round_keys (
        .rst     (1'b0),
        .key_in  (prev_key_s),
        .rcon    ({rcon_q, 24'h0}),
        .key_out (step_key_s)
    );

    // Next-state logic for the controller
    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        rcon_d       = rcon_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        accept_s     = 1'b0;
        expand_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    state_d      = ST_EXPAND;
                    rnd_d        = 4'd1;
                    rcon_d       = RCON_INIT;
                    keys_valid_d = 1'b0;
                    accept_s     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_EXPAND: begin
                expand_s = 1'b1;
                rnd_d    = rnd_q + 4'd1;
                rcon_d   = xtime(rcon_q);
                if (rnd_q == LAST_RND) begin
                    state_d      = ST_READY;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_EXPAND);
    end

    // Store write ports and read mux; reads always see the pre-edge contents
    always_comb begin
        store_d[0] = accept_s ? key_in : store_q[0];
        for (int i = 1; i < NUM_KEYS; i++) begin
            store_d[i] = (expand_s && (rnd_q == 4'(i))) ? step_key_s : store_q[i];
        end
        rd_key_d = (rd_addr < 4'(NUM_KEYS)) ? store_q[rd_addr] : 128'h0;
    end

    // State, store and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rnd_q        <= 4'd0;
            rcon_q       <= RCON_INIT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= 128'h0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                store_q[i] <= 128'h0;
            end
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_key_q     <= rd_key_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                store_q[i] <= store_d[i];
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl using FIPS-197 and all-zero key vectors.
module tb_key_expansion_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [127:0] exp_q [$];
    logic [3:0]   addr_q [$];

    key_expansion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start for one edge, leave inputs idle one time unit after it
    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Count edges until done rises, bounded; caller compares the count
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
        end
    endtask

    // Queue a read; expected value is pushed now, compared after the next edge
    task automatic read_push(input logic [3:0] a, input logic [127:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        addr_q.push_back(a);
    endtask

    task automatic test_reset();
        logic [127:0] e;
        logic [3:0]   a;
        reset = 1'b1; start = 1'b0; key_in = 128'h0; rd_addr = 4'd0;
        tick(); tick();
        reset = 1'b0;
        chk_cnt++;
        if ({busy, done, keys_valid} !== 3'b000) $display("FAIL reset_flags busy/done/kv=%b want 000", {busy, done, keys_valid});
        else pass_cnt++;
        read_push(4'd0, 128'h0);
        tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL reset_rd_key addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
    endtask

    task automatic test_fips();
        int cnt;
        logic [127:0] e;
        logic [3:0]   a;
        pulse_start(FIPS_KEY);
        chk_cnt++;
        if ({busy, keys_valid} !== 2'b10) $display("FAIL fips_busy busy/kv=%b want 10", {busy, keys_valid});
        else pass_cnt++;
        wait_done(cnt);
        chk_cnt++;
        if (cnt !== 10) $display("FAIL fips_latency edges_after_start=%0d want 10", cnt);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, keys_valid} !== 2'b01) $display("FAIL fips_ready busy/kv=%b want 01", {busy, keys_valid});
        else pass_cnt++;
        read_push(4'd1, FIPS_R1);
        tick();
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL fips_done_pulse done=%b want 0", done);
        else pass_cnt++;
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL fips_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
        read_push(4'd10, FIPS_R10); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL fips_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
        read_push(4'd0, FIPS_KEY); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL fips_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [127:0] e;
        logic [3:0]   a;
        for (int i = 11; i < 16; i++) begin
            read_push(4'(i), 128'h0);
            tick();
            e = exp_q.pop_front(); a = addr_q.pop_front();
            chk_cnt++;
            if (rd_key !== e) $display("FAIL oor_read addr=%0d got=%h want=%h", a, rd_key, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        int cnt;
        logic [127:0] e;
        logic [3:0]   a;
        pulse_start(FIPS_KEY);
        tick(); tick(); tick();
        key_in = 128'h0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cnt = 4;
        while (done !== 1'b1 && cnt < 30) begin
            tick();
            cnt++;
        end
        chk_cnt++;
        if (cnt !== 10) $display("FAIL ignore_latency edges_after_start=%0d want 10", cnt);
        else pass_cnt++;
        read_push(4'd10, FIPS_R10); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL ignore_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
        read_push(4'd0, FIPS_KEY); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL ignore_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic [127:0] e;
        logic [3:0]   a;
        rd_addr = 4'd10;
        pulse_start(128'h0);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({busy, done, keys_valid} !== 3'b000 || rd_key !== 128'h0)
            $display("FAIL midreset_outputs flags=%b rd_key=%h want 000/0", {busy, done, keys_valid}, rd_key);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        read_push(4'd1, 128'h0); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL midreset_store addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
        pulse_start(128'h0);
        wait_done(cnt);
        chk_cnt++;
        if (cnt !== 10 || keys_valid !== 1'b1) $display("FAIL zero_latency edges=%0d kv=%b want 10/1", cnt, keys_valid);
        else pass_cnt++;
        read_push(4'd1, ZERO_R1); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL zero_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
        read_push(4'd10, ZERO_R10); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL zero_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        int cnt;
        logic [127:0] e;
        logic [3:0]   a;
        pulse_start(FIPS_KEY);
        chk_cnt++;
        if ({busy, keys_valid} !== 2'b10) $display("FAIL restart_kv_drop busy/kv=%b want 10", {busy, keys_valid});
        else pass_cnt++;
        wait_done(cnt);
        chk_cnt++;
        if (cnt !== 10) $display("FAIL restart_latency edges_after_start=%0d want 10", cnt);
        else pass_cnt++;
        read_push(4'd10, FIPS_R10); tick();
        e = exp_q.pop_front(); a = addr_q.pop_front();
        chk_cnt++;
        if (rd_key !== e) $display("FAIL restart_read addr=%0d got=%h want=%h", a, rd_key, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_out_of_range();
        test_start_ignored();
        test_reset_mid();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
